full_mas_deser_ctrl: RTL and testbench
======================================

FULL_MAS_DESER_CTRL -- requirements
Module: full_mas_deser_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'h7E5A_A57E, lane-1 idle/alignment word.
REQ-002 SHALL have parameter SYNC_CONFIRM, default 3, consecutive aligned sync frames required to lock.
REQ-003 SHALL have parameter MAX_ERR, default 4, consecutive bad frames that drop lock.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port serial_i  input  2  bit 0 = control/5-bit lane, bit 1 = 32-bit data lane, one bit per clk each.
REQ-007 SHALL have port data_o  output  37  frame payload {lane1 word[31:0], lane0 word[4:0]}.
REQ-008 SHALL have port valid_o  output  1  data_o holds an undelivered frame.
REQ-009 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o & ready_i.
REQ-010 SHALL have port locked_o  output  1  frame alignment established.
REQ-011 SHALL have port overflow_o  output  1  sticky: at least one frame dropped.
REQ-012 SHALL have port clear_i  input  1  synchronous clear of overflow_o.

Function
REQ-013 SHALL shift each lane MSB-first into its own 32-bit register: next = {reg[30:0], serial_i[n]}; "current word" = value including this cycle's bit.
REQ-014 SHALL keep a 5-bit bit counter, 0..31, wrapping 31->0; frame boundary = counter==31.
REQ-015 SHALL implement states HUNT, VERIFY, LOCKED.
REQ-016 HUNT: every cycle compare current lane-1 word with SYNC_WORD; on match set counter to 0 next cycle, sync count=1, go VERIFY.
REQ-017 VERIFY: at each boundary, lane-1 word == SYNC_WORD increments sync count; reaching SYNC_CONFIRM goes LOCKED; any mismatch returns to HUNT.
REQ-018 LOCKED: at each boundary classify frame: SYNC (lane-1 == SYNC_WORD) -> idle, no output, error count cleared; DATA (lane-0 word[31]==1, lane-1 != SYNC_WORD) -> emit, error count cleared; otherwise BAD -> error count +1.
REQ-019 Error count reaching MAX_ERR SHALL go HUNT in the following cycle and drop locked_o same cycle as state change.
REQ-020 A DATA frame SHALL appear on data_o with valid_o=1 exactly one cycle after its boundary cycle.
REQ-021 data_o/valid_o SHALL hold stable while valid_o & !ready_i.
REQ-022 valid_o SHALL clear the cycle after valid_o & ready_i unless a new DATA frame loads that same cycle (then valid_o stays 1, data_o updates).
REQ-023 DATA frame at boundary while valid_o & !ready_i SHALL be dropped, held frame kept, overflow_o set next cycle.
REQ-024 clear_i SHALL clear overflow_o next cycle; simultaneous new overflow wins (overflow_o stays 1).
REQ-025 locked_o SHALL equal (state==LOCKED), registered.
REQ-026 Leaving LOCKED SHALL NOT discard a frame already in data_o; handshake completes normally.
REQ-027 In HUNT/VERIFY no frame SHALL be emitted.

Reset
REQ-028 On reset=0, SHALL asynchronously force: state HUNT, counter 0, shift registers 0, sync/error counts 0, data_o 0, valid_o 0, locked_o 0, overflow_o 0.
REQ-029 Reset mid-frame or mid-handshake SHALL discard all state; after release, lock SHALL be reacquired from HUNT.

Structure
REQ-030 SHALL place state enum, FRAME_BITS=32, DATA_W=37, default SYNC_WORD in shared package full_mas_deser_pkg.
REQ-031 SHALL instantiate sub-module deser_lane_shift (32-bit MSB-first shift register) once per lane.

Verification
REQ-032 SYNC_WORD x3 aligned after arbitrary 13-bit junk -> locked_o=1 one cycle after third boundary; valid_o never set.
REQ-033 Locked, DATA frame lane1=32'h1234_5678, lane0 word=32'h8000_0015, ready_i=1 -> data_o=37'h02468ACF15 ({32'h12345678,5'h15}), valid_o=1 one cycle after boundary, for 1 cycle.
REQ-034 Locked, ready_i=0, two DATA frames -> first frame held, second dropped, overflow_o=1; clear_i pulse -> overflow_o=0.
REQ-035 Locked, 4 consecutive BAD frames (lane0 word[31]=0, lane1 != SYNC) -> locked_o=0 after 4th boundary; 3 BAD then SYNC -> stays locked.
REQ-036 reset=0 asserted mid-VERIFY and mid-LOCKED with valid_o=1 -> all outputs 0 immediately (asynchronous), relock requires full SYNC_CONFIRM sequence.

Source files
------------

// File: rtl/full_mas_deser_pkg.sv
// Shared types and constants for the two-lane frame deserialiser.
package full_mas_deser_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned DATA_W     = 37;
  localparam int unsigned CTRL_BITS  = 5;

  localparam logic [FRAME_BITS-1:0] DEF_SYNC_WORD = 32'h7E5A_A57E;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/full_mas_deser_ctrl_lane_shift.sv
// One serial lane: 32-bit MSB-first shift register.
// cur_o is the word including the bit arriving this cycle.
module deser_lane_shift
  import full_mas_deser_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_in,
  output logic [FRAME_BITS-1:0] cur_o
);

  logic [FRAME_BITS-1:0] shreg;
  // The oldest bit falls off the top each cycle and never reaches a word.
  logic                  shreg_msb_unused;

  assign cur_o            = {shreg[FRAME_BITS-2:0], bit_in};
  assign shreg_msb_unused = shreg[FRAME_BITS-1];

  // Shift the new bit in at the LSB every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else begin
      shreg <= cur_o;
    end
  end

endmodule

// File: rtl/full_mas_deser_ctrl.sv
// Two-lane deserialiser: hunts for the lane-1 sync word, confirms
// alignment over several frames, then delivers DATA frames through a
// single-entry valid/ready output register with sticky overflow.
module full_mas_deser_ctrl
  import full_mas_deser_pkg::*;
#(
  parameter logic [FRAME_BITS-1:0] SYNC_WORD    = DEF_SYNC_WORD,
  parameter int unsigned           SYNC_CONFIRM = 3,
  parameter int unsigned           MAX_ERR      = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        serial_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              locked_o,
  output logic              overflow_o,
  input  logic              clear_i
);

  localparam int unsigned CW = 8;

  logic [FRAME_BITS-1:0] word0;
  logic [FRAME_BITS-1:0] word1;
  logic [4:0]            bit_cnt;
  logic [CW-1:0]         sync_cnt;
  logic [CW-1:0]         err_cnt;
  state_t                state;

  logic                  boundary;
  logic                  is_sync;
  logic                  is_data;
  logic                  load;
  logic                  drop;
  // Lane 0 carries a flag in bit 31 and payload in bits 4:0 only.
  logic [25:0]           lane0_mid_unused;

  deser_lane_shift u_lane0 (
    .clk    (clk),
    .reset  (reset),
    .bit_in (serial_i[0]),
    .cur_o  (word0)
  );

  deser_lane_shift u_lane1 (
    .clk    (clk),
    .reset  (reset),
    .bit_in (serial_i[1]),
    .cur_o  (word1)
  );

  assign lane0_mid_unused = word0[30:5];

  assign boundary = (bit_cnt == 5'(FRAME_BITS - 1));
  assign is_sync  = (word1 == SYNC_WORD);
  assign is_data  = word0[FRAME_BITS-1] && !is_sync;
  assign load     = (state == LOCKED) && boundary && is_data && (!valid_o || ready_i);
  assign drop     = (state == LOCKED) && boundary && is_data && valid_o && !ready_i;

  // Alignment FSM: bit counter, sync/error counts and registered lock flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      sync_cnt <= '0;
      err_cnt  <= '0;
      locked_o <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 5'd1;
      case (state)
        HUNT: begin
          if (is_sync) begin
            bit_cnt  <= '0;
            sync_cnt <= CW'(1);
            err_cnt  <= '0;
            if (SYNC_CONFIRM <= 1) begin
              state    <= LOCKED;
              locked_o <= 1'b1;
            end else begin
              state <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (is_sync) begin
              sync_cnt <= sync_cnt + CW'(1);
              if (sync_cnt + CW'(1) >= CW'(SYNC_CONFIRM)) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
                err_cnt  <= '0;
              end
            end else begin
              state    <= HUNT;
              sync_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (is_sync || is_data) begin
              err_cnt <= '0;
            end else if (err_cnt + CW'(1) >= CW'(MAX_ERR)) begin
              state    <= HUNT;
              locked_o <= 1'b0;
              err_cnt  <= '0;
              sync_cnt <= '0;
            end else begin
              err_cnt <= err_cnt + CW'(1);
            end
          end
        end
        default: begin
          state    <= HUNT;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on DATA frames, clear on handshake, hold otherwise.
  // Independent of state so a held frame survives loss of lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (load) begin
      data_o  <= {word1, word0[CTRL_BITS-1:0]};
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Sticky overflow: a drop in the same cycle as clear_i keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_mas_deser_ctrl.sv
// Scoreboard bench for full_mas_deser_ctrl: stimulus pushes expected
// frames, a negedge monitor pops and compares on every handshake.
module tb_full_mas_deser_ctrl;

  localparam logic [31:0] SYNC = 32'h7E5A_A57E;
  localparam logic [31:0] BADW = 32'h1111_2222;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [1:0]  serial_i = 2'b00;
  logic [36:0] data_o;
  logic        valid_o;
  logic        ready_i  = 1'b1;
  logic        locked_o;
  logic        overflow_o;
  logic        clear_i  = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;

  full_mas_deser_ctrl #(
    .SYNC_WORD    (SYNC),
    .SYNC_CONFIRM (3),
    .MAX_ERR      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_i   (serial_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .locked_o   (locked_o),
    .overflow_o (overflow_o),
    .clear_i    (clear_i)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted frame must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got data_o=%h, expected no frame", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_o !== mon_exp) begin
          errors++;
          $display("FAIL frame_data: got data_o=%h, expected %h", data_o, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b1, input logic b0);
    serial_i = {b1, b0};
    @(posedge clk);
    #1;
  endtask

  // clr_last pulses clear_i during the boundary bit of this frame.
  task automatic send_frame(input logic [31:0] w1, input logic [31:0] w0, input logic clr_last);
    for (int i = 31; i >= 0; i--) begin
      clear_i = (i == 0) ? clr_last : 1'b0;
      send_bit(w1[i], w0[i]);
    end
    clear_i = 1'b0;
  endtask

  task automatic send_junk();
    logic [12:0] junk;
    junk = 13'h1ABC;
    for (int i = 12; i >= 0; i--) send_bit(junk[i], 1'b0);
  endtask

  task automatic acquire(input string tag);
    send_junk();
    for (int n = 1; n <= 3; n++) begin
      send_frame(SYNC, 32'h0, 1'b0);
      check($sformatf("%s_locked_after_sync%0d", tag, n), 64'(locked_o), 64'(n == 3));
    end
    check({tag, "_no_valid"}, 64'(valid_o), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},     64'(data_o),     64'd0);
    check({tag, "_valid"},    64'(valid_o),    64'd0);
    check({tag, "_locked"},   64'(locked_o),   64'd0);
    check({tag, "_overflow"}, 64'(overflow_o), 64'd0);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Lock from junk, then a single DATA frame with ready high.
    acquire("init");
    exp_q.push_back(37'h02468ACF15);
    send_frame(32'h1234_5678, 32'h8000_0015, 1'b0);
    check("data_valid", 64'(valid_o), 64'd1);
    check("data_value", 64'(data_o), 64'h02468ACF15);
    send_frame(SYNC, 32'h0, 1'b0);
    check("valid_cleared", 64'(valid_o), 64'd0);

    // Back-to-back DATA frames, different payload bit patterns.
    exp_q.push_back({32'hDEAD_BEEF, 5'h0A});
    send_frame(32'hDEAD_BEEF, 32'hFFFF_FFEA, 1'b0);
    exp_q.push_back({32'h0000_0001, 5'h1F});
    send_frame(32'h0000_0001, 32'h8000_001F, 1'b0);
    send_frame(SYNC, 32'h0, 1'b0);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Handshake and new load on the same edge: valid stays, data updates.
    ready_i = 1'b0;
    exp_q.push_back({32'h3C3C_C3C3, 5'h04});
    send_frame(32'h3C3C_C3C3, 32'h8000_0004, 1'b0);
    exp_q.push_back({32'h5555_AAAA, 5'h1B});
    for (int i = 31; i >= 1; i--) send_bit(1'(32'h5555_AAAA >> i), 1'(32'h8000_001B >> i));
    ready_i = 1'b1;
    send_bit(1'b0, 1'b1);
    check("swap_valid", 64'(valid_o), 64'd1);
    check("swap_data", 64'(data_o), 64'({32'h5555_AAAA, 5'h1B}));
    check("swap_no_overflow", 64'(overflow_o), 64'd0);
    send_frame(SYNC, 32'h0, 1'b0);

    // Overflow: held frame kept, second dropped; set beats simultaneous clear.
    ready_i = 1'b0;
    exp_q.push_back({32'hA5A5_0F0F, 5'h03});
    send_frame(32'hA5A5_0F0F, 32'h8000_0003, 1'b0);
    send_frame(32'hCAFE_F00D, 32'h8000_001C, 1'b1);
    check("ovf_set_beats_clear", 64'(overflow_o), 64'd1);
    check("ovf_held_valid", 64'(valid_o), 64'd1);
    check("ovf_held_data", 64'(data_o), 64'({32'hA5A5_0F0F, 5'h03}));
    send_frame(SYNC, 32'h0, 1'b1);
    check("ovf_cleared", 64'(overflow_o), 64'd0);
    ready_i = 1'b1;
    send_frame(SYNC, 32'h0, 1'b0);
    check("ovf_drained", 64'(exp_q.size()), 64'd0);

    // Three BAD frames then SYNC keeps lock.
    for (int n = 1; n <= 3; n++) send_frame(BADW, 32'h0, 1'b0);
    check("bad3_locked", 64'(locked_o), 64'd1);
    send_frame(SYNC, 32'h0, 1'b0);
    check("bad3_sync_locked", 64'(locked_o), 64'd1);

    // Held frame survives loss of lock after four BAD frames.
    ready_i = 1'b0;
    exp_q.push_back({32'h0BAD_F00D, 5'h11});
    send_frame(32'h0BAD_F00D, 32'h8000_0011, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      send_frame(BADW, 32'h0, 1'b0);
      check($sformatf("bad_run_locked_%0d", n), 64'(locked_o), 64'(n < 4));
    end
    check("unlocked_held_valid", 64'(valid_o), 64'd1);
    ready_i = 1'b1;
    // DATA-shaped frame while hunting must not be emitted.
    send_frame(32'h0BAD_F00D, 32'h8000_0011, 1'b0);
    check("hunt_no_emit", 64'(valid_o), 64'd0);

    // Asynchronous reset while locked with a held frame and overflow set.
    acquire("relock0");
    ready_i = 1'b0;
    exp_q.push_back({32'h600D_CAFE, 5'h09});
    send_frame(32'h600D_CAFE, 32'h8000_0009, 1'b0);
    send_frame(32'h0F0F_0F0F, 32'h8000_0011, 1'b0);
    check("pre_reset_ovf", 64'(overflow_o), 64'd1);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset_locked");
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    ready_i = 1'b1;
    acquire("relock1");

    // Asynchronous reset mid-VERIFY.
    send_frame(SYNC, 32'h0, 1'b0);
    for (int n = 1; n <= 4; n++) send_frame(BADW, 32'h0, 1'b0);
    check("dropped_before_verify", 64'(locked_o), 64'd0);
    send_junk();
    send_frame(SYNC, 32'h0, 1'b0);
    send_frame(SYNC, 32'h0, 1'b0);
    check("mid_verify_unlocked", 64'(locked_o), 64'd0);
    for (int i = 0; i < 7; i++) send_bit(1'(SYNC >> (31 - i)), 1'b0);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset_verify");
    @(posedge clk);
    #1 reset = 1'b1;
    acquire("relock2");

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
